// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed seven-segment scan driver:
// active-low segment patterns, decimal point bit and blink phase encoding.
package seg7_pkg;

    // Segment vector, active-low, ordered {dp,g,f,e,d,c,b,a}.
    typedef logic [7:0] seg_t;

    localparam int   DP_BIT    = 7;
    localparam seg_t SEG_BLANK = 8'hFF;

    // Hex 0..F glyphs with the decimal point off.
    localparam seg_t SEG_PATTERNS [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    // Whole-display blink phase; also the state of the blink FSM.
    typedef enum logic {
        PHASE_ON  = 1'b0,
        PHASE_OFF = 1'b1
    } blink_phase_e;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Host-side bus of the scan driver plus the display pins and the blink
// FSM state for observation.
//
// Handshake: load is a single-cycle strobe with no ready/backpressure. The
// driver samples digits, dp_in and digit_en on every rising edge where load
// is 1 and always accepts. blank_lz and blink_en are level controls sampled
// live on every edge.
interface seg7_scan_driver_if
    import seg7_pkg::*;
#(
    parameter int N_DIGITS = 4
) ();
    logic [4*N_DIGITS-1:0] digits;
    logic [N_DIGITS-1:0]   dp_in;
    logic [N_DIGITS-1:0]   digit_en;
    logic                  load;
    logic                  blank_lz;
    logic                  blink_en;
    logic [N_DIGITS-1:0]   anodo;
    seg_t                  catodo;
    blink_phase_e          phase;

    modport master (
        output digits, dp_in, digit_en, load, blank_lz, blink_en,
        input  anodo, catodo, phase
    );

    modport slave (
        input  digits, dp_in, digit_en, load, blank_lz, blink_en,
        output anodo, catodo, phase
    );
endinterface

// File: rtl/seg7_decoder.sv
// Hex digit plus decimal point to active-low seven-segment pattern.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       dp,
    output seg_t       seg
);

    // Table lookup, then pull the dp segment low when requested.
    always_comb begin
        seg = SEG_PATTERNS[hex];
        if (dp) seg[DP_BIT] = 1'b0;
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode display driver: one digit per slot, an
// anti-ghosting blank at the start of each slot, double-buffered content,
// leading-zero blanking and a whole-display blink.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int SLOT_CYCLES  = 25000,
    parameter int BLANK_CYCLES = 250,
    parameter int BLINK_SCANS  = 250
) (
    input  logic               clk,
    input  logic               rst_n,
    seg7_scan_driver_if.slave  bus
);

    localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CNT_W  = $clog2(SLOT_CYCLES);
    localparam int SCAN_W = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIGITS - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(BLINK_SCANS - 1);

    logic [CNT_W-1:0]      slot_cnt;
    logic [IDX_W-1:0]      idx;
    logic [SCAN_W-1:0]     scan_cnt, scan_cnt_d;
    blink_phase_e          phase_q, phase_d;

    logic [4*N_DIGITS-1:0] pend_digits, act_digits;
    logic [N_DIGITS-1:0]   pend_dp, act_dp;
    logic [N_DIGITS-1:0]   pend_en, act_en;

    logic                  slot_wrap, scan_wrap;
    logic [N_DIGITS-1:0]   lz_dark;
    logic                  lz_run;
    logic [3:0]            cur_hex;
    logic                  cur_dp, cur_en, cur_lz;
    logic                  lit;
    seg_t                  dec_seg;
    logic [N_DIGITS-1:0]   anodo_d;
    seg_t                  catodo_d;

    assign slot_wrap = (slot_cnt == CNT_LAST);
    assign scan_wrap = slot_wrap && (idx == IDX_LAST);

    // Slot counter and digit index; index advances when a slot completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            idx      <= '0;
        end else if (slot_wrap) begin
            slot_cnt <= '0;
            idx      <= scan_wrap ? '0 : idx + 1'b1;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    // Double buffer: load fills pending; active only changes at a slot
    // boundary, taking a same-cycle load directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_digits <= '0;
            pend_dp     <= '0;
            pend_en     <= '1;
            act_digits  <= '0;
            act_dp      <= '0;
            act_en      <= '1;
        end else begin
            if (bus.load) begin
                pend_digits <= bus.digits;
                pend_dp     <= bus.dp_in;
                pend_en     <= bus.digit_en;
            end
            if (slot_wrap) begin
                act_digits <= bus.load ? bus.digits   : pend_digits;
                act_dp     <= bus.load ? bus.dp_in    : pend_dp;
                act_en     <= bus.load ? bus.digit_en : pend_en;
            end
        end
    end

    // Blink FSM state register and completed-scan counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= PHASE_ON;
            scan_cnt <= '0;
        end else begin
            phase_q  <= phase_d;
            scan_cnt <= scan_cnt_d;
        end
    end

    // Blink next state: toggle after BLINK_SCANS full scans; disabling
    // blink snaps back to the on phase with a fresh count.
    always_comb begin
        phase_d    = phase_q;
        scan_cnt_d = scan_cnt;
        if (!bus.blink_en) begin
            phase_d    = PHASE_ON;
            scan_cnt_d = '0;
        end else if (scan_wrap) begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt_d = '0;
                unique case (phase_q)
                    PHASE_ON:  phase_d = PHASE_OFF;
                    PHASE_OFF: phase_d = PHASE_ON;
                    default:   phase_d = PHASE_ON;
                endcase
            end else begin
                scan_cnt_d = scan_cnt + 1'b1;
            end
        end
    end

    // Leading-zero mask from the top digit down, then pick the current digit.
    always_comb begin
        lz_run  = 1'b1;
        lz_dark = '0;
        cur_hex = 4'h0;
        cur_dp  = 1'b0;
        cur_en  = 1'b0;
        cur_lz  = 1'b0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            lz_run     = lz_run && (act_digits[4*i +: 4] == 4'h0) && !act_dp[i];
            lz_dark[i] = bus.blank_lz && lz_run && (i != 0);
        end
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_hex = act_digits[4*i +: 4];
                cur_dp  = act_dp[i];
                cur_en  = act_en[i];
                cur_lz  = lz_dark[i];
            end
        end
    end

    seg7_decoder u_decoder (
        .hex (cur_hex),
        .dp  (cur_dp),
        .seg (dec_seg)
    );

    // Next display drive: dark during the blank window, disabled or
    // leading-zero digits, and the blink off phase.
    always_comb begin
        lit = cur_en && !cur_lz
           && (!bus.blink_en || (phase_q == PHASE_ON))
           && (int'(slot_cnt) >= BLANK_CYCLES);
        anodo_d = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (lit && (idx == IDX_W'(i))) anodo_d[i] = 1'b0;
        end
        catodo_d = lit ? dec_seg : SEG_BLANK;
    end

    // Registered display pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.anodo  <= '1;
            bus.catodo <= SEG_BLANK;
        end else begin
            bus.anodo  <= anodo_d;
            bus.catodo <= catodo_d;
        end
    end

    assign bus.phase = phase_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a short slot (4 cycles, 1 blank)
// and a 2-scan blink half-period.
module tb_seg7_scan_driver;
    import seg7_pkg::*;

    localparam int N     = 4;
    localparam int SLOT  = 4;
    localparam int BLANK = 1;
    localparam int BLINK = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    seg7_scan_driver_if #(.N_DIGITS(N)) bus ();

    seg7_scan_driver #(
        .N_DIGITS     (N),
        .SLOT_CYCLES  (SLOT),
        .BLANK_CYCLES (BLANK),
        .BLINK_SCANS  (BLINK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock
    always #5 clk = ~clk;

    // One rising edge, then park on the falling edge for sampling/driving.
    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Registered outputs show the scan position of the previous cycle.
    function automatic int out_slot();
        return ((cyc - 1) / SLOT) % N;
    endfunction

    function automatic int out_cnt();
        return (cyc - 1) % SLOT;
    endfunction

    task automatic wait_until(input int s, input int c);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(out_slot() == s && out_cnt() == c) && n < 64);
        if (!(out_slot() == s && out_cnt() == c)) begin
            checks++;
            errors++;
            $display("FAIL wait_until slot=%0d cnt=%0d not reached", s, c);
        end
    endtask

    task automatic check(input string tag, input logic [3:0] an_e, input logic [7:0] cat_e);
        checks++;
        assert ({bus.anodo, bus.catodo} === {an_e, cat_e})
        else begin
            errors++;
            $error("FAIL %s anodo=%b catodo=%h expected anodo=%b catodo=%h",
                   tag, bus.anodo, bus.catodo, an_e, cat_e);
        end
    endtask

    task automatic load_vals(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
        bus.digits   = d;
        bus.dp_in    = dp;
        bus.digit_en = en;
        bus.load     = 1'b1;
        tick();
        bus.load     = 1'b0;
    endtask

    initial begin
        bus.digits   = '0;
        bus.dp_in    = '0;
        bus.digit_en = '1;
        bus.load     = 1'b0;
        bus.blank_lz = 1'b0;
        bus.blink_en = 1'b0;
        rst_n        = 1'b1;
        #2 rst_n     = 1'b0;
        #10;
        check("reset_async", 4'hF, 8'hFF);

        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;

        // Basic scan of 1234
        load_vals(16'h1234, 4'h0, 4'hF);
        check("first_slot_blank", 4'hF, 8'hFF);
        tick();
        check("first_slot_old_content", 4'b1110, 8'hC0);
        wait_until(0, 1); check("slot0_digit4", 4'b1110, 8'h99);
        wait_until(1, 0); check("slot1_blank", 4'hF, 8'hFF);
        wait_until(1, 2); check("slot1_digit3", 4'b1101, 8'hB0);
        wait_until(2, 1); check("slot2_digit2", 4'b1011, 8'hA4);
        wait_until(3, 1); check("slot3_digit1", 4'b0111, 8'hF9);

        // Leading-zero blanking
        bus.blank_lz = 1'b1;
        load_vals(16'h0050, 4'h0, 4'hF);
        wait_until(0, 1); check("lz_0050_d0", 4'b1110, 8'hC0);
        wait_until(1, 1); check("lz_0050_d1", 4'b1101, 8'h92);
        wait_until(2, 1); check("lz_0050_d2_dark", 4'hF, 8'hFF);
        wait_until(3, 1); check("lz_0050_d3_dark", 4'hF, 8'hFF);
        load_vals(16'h0000, 4'h0, 4'hF);
        wait_until(0, 1); check("lz_0000_d0", 4'b1110, 8'hC0);
        wait_until(1, 1); check("lz_0000_d1_dark", 4'hF, 8'hFF);
        wait_until(3, 1); check("lz_0000_d3_dark", 4'hF, 8'hFF);

        // Letters, decimal point, digit enable
        bus.blank_lz = 1'b0;
        load_vals(16'hABCD, 4'b0001, 4'hF);
        wait_until(0, 1); check("abcd_d0_dp", 4'b1110, 8'h21);
        wait_until(2, 1); check("abcd_d2", 4'b1011, 8'h83);
        wait_until(3, 1); check("abcd_d3", 4'b0111, 8'h88);
        load_vals(16'hABCD, 4'b0001, 4'b0111);
        wait_until(0, 1); check("en0111_d0", 4'b1110, 8'h21);
        wait_until(3, 1); check("en0111_d3_dark", 4'hF, 8'hFF);

        // Load mid-slot: output at cnt 1 means the DUT is at cnt 2
        wait_until(0, 1);
        load_vals(16'h9999, 4'h0, 4'hF);
        check("midslot_keep_cnt2", 4'b1110, 8'h21);
        tick();
        check("midslot_keep_cnt3", 4'b1110, 8'h21);
        wait_until(1, 1); check("midslot_next_slot", 4'b1101, 8'h90);

        // Load on the wrap cycle: output at cnt 2 means the DUT is at cnt 3
        wait_until(1, 2);
        load_vals(16'h0700, 4'h0, 4'hF);
        check("wrap_load_same_slot", 4'b1101, 8'h90);
        wait_until(2, 1); check("wrap_load_next_slot", 4'b1011, 8'hF8);
        wait_until(3, 1); check("wrap_load_d3", 4'b0111, 8'hC0);

        // Blink enabled while the DUT sits at the start of a scan
        wait_until(3, 3);
        bus.blink_en = 1'b1;
        wait_until(0, 1); check("blink_s1_lit", 4'b1110, 8'hC0);
        wait_until(2, 1); check("blink_s1_d2_lit", 4'b1011, 8'hF8);
        wait_until(0, 1); check("blink_s2_lit", 4'b1110, 8'hC0);
        wait_until(0, 1); check("blink_s3_dark", 4'hF, 8'hFF);
        wait_until(2, 2); check("blink_s3_d2_dark", 4'hF, 8'hFF);
        wait_until(0, 1); check("blink_s4_dark", 4'hF, 8'hFF);
        wait_until(0, 1); check("blink_s5_lit", 4'b1110, 8'hC0);
        wait_until(0, 1); check("blink_s6_lit", 4'b1110, 8'hC0);
        wait_until(0, 1); check("blink_s7_dark", 4'hF, 8'hFF);
        wait_until(1, 1); check("blink_s7_d1_dark", 4'hF, 8'hFF);
        bus.blink_en = 1'b0;
        tick();
        check("blink_release_lit", 4'b1101, 8'hC0);

        // Asynchronous reset mid-slot of digit 2
        wait_until(2, 2); check("pre_reset_d2", 4'b1011, 8'hF8);
        #2 rst_n = 1'b0;
        #1 check("reset_midslot_async", 4'hF, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        tick(); check("restart_blank", 4'hF, 8'hFF);
        tick(); check("restart_digit0", 4'b1110, 8'hC0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter N_DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 Parameter SLOT_CYCLES, default 25000: clock cycles per digit slot, minimum 2.
REQ-003 Parameter BLANK_CYCLES, default 250: anti-ghosting off-time at the start of each slot, range 0..SLOT_CYCLES-1.
REQ-004 Parameter BLINK_SCANS, default 250: complete scans per blink half-period, minimum 1.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  reset; asynchronous assertion, active-low.
REQ-007 digits  in  4*N_DIGITS  hex value per digit; digit i is digits[4i+3:4i]; digit 0 is least significant (rightmost).
REQ-008 dp_in  in  N_DIGITS  decimal point request per digit, 1 = lit.
REQ-009 load  in  1  single-cycle strobe; captures digits, dp_in and digit_en.
REQ-010 digit_en  in  N_DIGITS  per-digit enable, 0 = digit dark.
REQ-011 blank_lz  in  1  leading-zero blanking enable, sampled live.
REQ-012 blink_en  in  1  whole-display blink enable, sampled live.
REQ-013 anodo  out  N_DIGITS  common-anode select, active-low, bit i drives digit i.
REQ-014 catodo  out  8  segments, active-low, order {dp,g,f,e,d,c,b,a}.

Function
REQ-015 Slot counter shall count 0..SLOT_CYCLES-1 and wrap; on wrap the digit index shall advance by one, modulo N_DIGITS (N_DIGITS-1 wraps to 0).
REQ-016 anodo and catodo shall be registered: they reflect the counter and index values one cycle after those values change.
REQ-017 In the active slot of digit i, anodo shall be all ones except bit i = 0, and catodo shall be the digit's pattern.
REQ-018 Patterns, hex 0..F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E; a lit decimal point clears bit 7.
REQ-019 While the slot counter < BLANK_CYCLES, anodo shall be all ones and catodo 8'hFF.
REQ-020 load shall write a pending register; pending shall transfer to the active register only at a slot wrap, so a slot never changes content mid-slot.
REQ-021 load on the same cycle as a slot wrap shall transfer the new value directly to the active register for the next slot.
REQ-022 A digit shall be dark (anodo all ones, catodo 8'hFF) when digit_en[i]=0, or when blank_lz=1 and it and all higher digits are zero with no dp; digit 0 is never leading-zero blanked.
REQ-023 Blink phase shall toggle after every BLINK_SCANS completed scans (index wrap N_DIGITS-1 -> 0); in the off phase anodo shall be all ones and catodo 8'hFF.
REQ-024 blink_en=0 shall force blink phase to on and clear the scan counter in the same cycle; the display shall resume on the next registered output.

Reset
REQ-025 rst_n=0 shall asynchronously set anodo to all ones, catodo 8'hFF, slot counter 0, index 0, blink phase on, scan count 0, and pending/active digits 0, dp 0, digit_en all ones.
REQ-026 After rst_n release, scanning shall start at digit 0 with a full slot, BLANK_CYCLES included.

Structure
REQ-027 Package seg7_pkg shall hold the 16-entry active-low segment pattern constant array, the DP bit index, and the segment vector typedef.
REQ-028 Sub-module seg7_decoder (4-bit hex + dp in, 8-bit active-low pattern out, combinational) shall be the single decode point.

Verification (N_DIGITS=4, SLOT_CYCLES=4, BLANK_CYCLES=1, BLINK_SCANS=2)
REQ-029 Reset, then load digits=16'h1234, digit_en=4'hF -> slot 0 anodo=4'b1110 catodo=8'h99; slot 1 anodo=4'b1101 catodo=8'hB0; blank cycle anodo=4'hF catodo=8'hFF.
REQ-030 digits=16'h0050, blank_lz=1 -> slots 3,2 dark; slot 1 catodo=8'h92; slot 0 catodo=8'hC0; digits=16'h0000 -> only digit 0 lit with 8'hC0.
REQ-031 digits=16'hABCD, dp_in=4'b0001 -> slot 0 catodo=8'h21; slot 3 catodo=8'h88; digit_en=4'b0111 -> slot 3 dark.
REQ-032 load 16'h9999 at slot-counter 2 -> remainder of the current slot keeps old value; next slot shows 8'h90; load on a wrap cycle -> new value appears in the next slot.
REQ-033 blink_en=1 -> 2 scans lit, 2 scans anodo=4'hF, repeating; blink_en=0 during off phase -> lit on next registered output.
REQ-034 rst_n pulsed low mid-slot of digit 2 -> anodo=4'hF and catodo=8'hFF immediately, no clock needed; restart at digit 0.
